conv_viterbi_dec: RTL and testbench
===================================

Name: conv_viterbi_dec

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, K=3 convolutional code.
- Generators G0=7 (octal) and G1=5 (octal).
- Sits on the receive side of the convolutional encoder, in the same clk20M_sig domain.
- Accepts one 2-bit code symbol per valid cycle and emits one decoded bit per valid cycle after a fixed decision delay.
- Uses register-exchange survivor memory, with no traceback RAM.

Parameters:
- TB_DEPTH, 16: survivor path length in bits (decision delay); legal range 4..64.
- PM_W, 5: path-metric width in bits; saturating.
- INIT_PM, 7: reset metric for states 1..3 (state 0 resets to 0); must be < 2^PM_W.

Ports:
- clk20M_sig  in   1  system clock, 20 MHz; all logic on rising edge
- reset_sig   in   1  asynchronous, active-low reset
- in_valid    in   1  code_in carries a symbol this cycle
- code_in     in   2  [1] = G0 (7) bit, [0] = G1 (5) bit of the encoder output
- out_valid   out  1  dec_out holds a decoded bit; registered, one-cycle pulse per symbol
- dec_out     out  1  decoded information bit
- pm_min      out  PM_W  normalized metric of the winning state (debug/BER monitor); 0 after normalization

Behaviour:
- Encoder model:
  - State S = {b[n-1], b[n-2]}; input u.
  - Output c1 = u^b[n-1]^b[n-2], c0 = u^b[n-2].
  - Next state = {u, b[n-1]}.
- Reset (async assert, sync-free release):
  - PM[0]=0, PM[1..3]=INIT_PM.
  - All path registers = 0; symbol counter = 0.
  - out_valid=0, dec_out=0, pm_min=0.
- Branch metric: BM = Hamming distance between code_in and the expected {c1,c0}; range 0..2.
- ACS (add-compare-select), one per accepted symbol, all four states in parallel in one cycle:
  - For next state ns={u,m}, the predecessors are p0={m,0} and p1={m,1}.
  - Candidate metric = PM[p] + BM(p,u), saturating at 2^PM_W-1.
  - Select the smaller candidate. On a tie, select p0 (lower-index predecessor).
- Normalization (same cycle): subtract the minimum of the four new metrics from all four before registering. Metrics therefore never wrap.
- Survivor memory:
  - path[ns] <= {path[sel][TB_DEPTH-2:0], u}.
  - Bit 0 is the newest bit; bit TB_DEPTH-1 is the oldest.
- Decision:
  - Best state = minimum of the new metrics; on a tie, the lowest state index wins.
  - dec_out <= new path[best][TB_DEPTH-1]; pm_min <= 0 (post-normalization min). The port exists so later revisions can export the pre-normalization min. Verification checks pm_min == 0 after the first decision.
- Latency and counting:
  - The symbol counter saturates at TB_DEPTH-1.
  - out_valid <= in_valid && (counter == TB_DEPTH-1, evaluated after increment).
  - Decoded bit j appears one cycle after input symbol j+TB_DEPTH-1 is accepted.
  - The first TB_DEPTH-1 symbols produce no output.
- in_valid=0: all metrics, paths and the counter hold; out_valid=0; dec_out holds its last value.
- Back-to-back in_valid: one output per cycle, with no bubbles.
- Reset mid-stream: everything returns to reset values immediately. The decode restarts from state 0 and the counter refills before out_valid reasserts.
- No flush input: the final TB_DEPTH-1 bits of a stream come out only when further symbols are pushed. The bench must pad with symbols encoding zeros.

Test Plan:
1. Error-free stream.
   - Stimulus: after reset, drive code symbols 11,10,00,01,01,11 (encoding of 1,0,1,1,0,0), followed by 20 symbols of 00.
   - Required: first out_valid one cycle after the 16th symbol; decoded bits 1,0,1,1,0,0 then zeros; pm_min=0 throughout.
2. Single-error correction.
   - Stimulus: same stream with symbol 3 flipped to 10.
   - Required: identical decoded bits to scenario 1.
3. Gapped input.
   - Stimulus: scenario 1 with in_valid deasserted for 3 cycles between every symbol.
   - Required: the same bit sequence; out_valid pulses only in the cycle after each accepted symbol; state frozen during gaps.
4. Random stream.
   - Stimulus: 2000 random bits through a bench reference encoder, with back-to-back in_valid.
   - Required: output equals input delayed by TB_DEPTH-1 symbols, zero mismatches. Then inject isolated errors at least 10 symbols apart: still zero mismatches.
5. Reset mid-stream.
   - Stimulus: assert reset_sig=0 for one cycle, asynchronously, mid-decode.
   - Required: out_valid drops the same cycle; PM returns to {0,7,7,7}; no output for the next 15 symbols; a new stream decodes correctly.
6. Tie handling.
   - Stimulus: 40 symbols of 11 from reset.
   - Required: deterministic output that matches the bench model using p0-preference and lowest-index best-state tie rules, bit-exact; no X on dec_out.

Source files
------------

// File: rtl/conv_viterbi_dec.sv
// conv_viterbi_dec: hard-decision Viterbi decoder for the rate-1/2, K=3
// convolutional code with generators 7 and 5 (octal). Four-state trellis,
// add-compare-select every accepted symbol, with metric normalisation in the
// same cycle and register-exchange survivor paths. There is no traceback RAM.
`timescale 1ns/1ps

module conv_viterbi_dec #(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 5,
   parameter int INIT_PM  = 7
) (
   input  logic            clk20M_sig,
   input  logic            reset_sig,
   input  logic            in_valid,
   input  logic [1:0]      code_in,
   output logic            out_valid,
   output logic            dec_out,
   output logic [PM_W-1:0] pm_min
);

   localparam int              CNT_W    = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);
   localparam logic [PM_W-1:0]  PM_MAX   = {PM_W{1'b1}};
   localparam logic [PM_W-1:0]  PM_INIT  = PM_W'(INIT_PM);

   // Registered trellis state
   logic [PM_W-1:0]     pm   [4];
   logic [TB_DEPTH-1:0] path [4];
   logic [CNT_W-1:0]    cnt;

   // ACS intermediate values
   logic [1:0]          pred0     [4];
   logic [1:0]          pred1     [4];
   logic [PM_W-1:0]     cand0     [4];
   logic [PM_W-1:0]     cand1     [4];
   logic                take1     [4];
   logic [PM_W-1:0]     pm_acs    [4];
   logic [PM_W-1:0]     pm_next   [4];
   logic [TB_DEPTH-1:0] path_next [4];
   logic [1:0]          best;
   logic [PM_W-1:0]     pm_best;
   logic                cnt_full;

   // Encoder output {c1,c0} for state {b[n-1],b[n-2]} and input u, compared
   // against the received symbol; the result is the Hamming distance 0..2.
   function automatic logic [1:0] branch_metric(input logic [1:0] rx,
                                                input logic [1:0] st,
                                                input logic       u);
      logic [1:0] exp_code;
      logic [1:0] diff;
      exp_code = {u ^ st[1] ^ st[0], u ^ st[0]};
      diff     = rx ^ exp_code;
      return {1'b0, diff[1]} + {1'b0, diff[0]};
   endfunction

   // Metric addition that sticks at the all-ones value instead of wrapping.
   function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                               input logic [1:0]      b);
      logic [PM_W:0] sum;
      sum = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
      return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
   endfunction

   // Add-compare-select for the four next states: ns={u,m} is reached from
   // {m,0} or {m,1}; a tie keeps the lower-index predecessor {m,0}.
   always_comb begin
      for (int ns = 0; ns < 4; ns++) begin
         pred0[ns] = {ns[0], 1'b0};
         pred1[ns] = {ns[0], 1'b1};
         cand0[ns] = sat_add(pm[pred0[ns]], branch_metric(code_in, pred0[ns], ns[1]));
         cand1[ns] = sat_add(pm[pred1[ns]], branch_metric(code_in, pred1[ns], ns[1]));
         take1[ns] = (cand1[ns] < cand0[ns]);
         if (take1[ns]) begin
            pm_acs[ns]    = cand1[ns];
            path_next[ns] = {path[pred1[ns]][TB_DEPTH-2:0], ns[1]};
         end else begin
            pm_acs[ns]    = cand0[ns];
            path_next[ns] = {path[pred0[ns]][TB_DEPTH-2:0], ns[1]};
         end
      end
   end

   // Pick the winning state (lowest index on a tie) and normalise all metrics
   // against its value so the stored metrics stay small.
   always_comb begin
      best    = 2'd0;
      pm_best = pm_acs[0];
      for (int s = 1; s < 4; s++) begin
         if (pm_acs[s] < pm_best) begin
            best    = 2'(s);
            pm_best = pm_acs[s];
         end
      end
      for (int s = 0; s < 4; s++) begin
         pm_next[s] = pm_acs[s] - pm_best;
      end
   end

   // A symbol produces a decision once TB_DEPTH-1 earlier symbols have filled
   // the survivor registers, so the oldest bit of the winning path is final.
   assign cnt_full = (cnt == CNT_LAST);

   // Trellis update: metrics, survivor paths and fill counter advance only on
   // accepted symbols and hold otherwise.
   always_ff @(posedge clk20M_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         for (int s = 0; s < 4; s++) begin
            pm[s]   <= (s == 0) ? '0 : PM_INIT;
            path[s] <= '0;
         end
         cnt <= '0;
      end else if (in_valid) begin
         for (int s = 0; s < 4; s++) begin
            pm[s]   <= pm_next[s];
            path[s] <= path_next[s];
         end
         if (!cnt_full) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Output registers: one-cycle valid pulse per decided symbol; the decoded
   // bit holds between decisions.
   always_ff @(posedge clk20M_sig or negedge reset_sig) begin
      if (!reset_sig) begin
         out_valid <= 1'b0;
         dec_out   <= 1'b0;
         pm_min    <= '0;
      end else begin
         out_valid <= in_valid && cnt_full;
         if (in_valid && cnt_full) begin
            dec_out <= path_next[best][TB_DEPTH-1];
            pm_min  <= pm_next[best];
         end
      end
   end

endmodule

// File: tb/tb_conv_viterbi_dec.sv
// tb_conv_viterbi_dec: directed, table-driven bench for conv_viterbi_dec with
// a small reference encoder and an independent trellis model for tie cases.
`timescale 1ns/1ps

module tb_conv_viterbi_dec;

   localparam int TB_DEPTH = 16;
   localparam int PM_W     = 5;
   localparam int INIT_PM  = 7;
   localparam int PAD      = TB_DEPTH - 1;
   localparam int S1_LEN   = 26;
   localparam int N_RAND   = 2000;
   localparam int PM_SAT   = (1 << PM_W) - 1;

   logic            clk20M_sig = 1'b0;
   logic            reset_sig;
   logic            in_valid;
   logic [1:0]      code_in;
   logic            out_valid;
   logic            dec_out;
   logic [PM_W-1:0] pm_min;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] code;
      logic       exp_valid;
      logic       exp_bit;
   } vec_t;

   vec_t vecs [S1_LEN];
   int   rand_bits [N_RAND];

   // Reference trellis model state
   int                  m_pm   [4];
   logic [TB_DEPTH-1:0] m_path [4];
   int                  m_cnt;
   logic                m_valid;
   logic                m_dec;

   conv_viterbi_dec #(
      .TB_DEPTH (TB_DEPTH),
      .PM_W     (PM_W),
      .INIT_PM  (INIT_PM)
   ) dut (
      .clk20M_sig (clk20M_sig),
      .reset_sig  (reset_sig),
      .in_valid   (in_valid),
      .code_in    (code_in),
      .out_valid  (out_valid),
      .dec_out    (dec_out),
      .pm_min     (pm_min)
   );

   // 20 MHz clock
   always #25 clk20M_sig = ~clk20M_sig;

   // Time limit so a stuck run still ends with a report
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [1:0] encodeBit(input logic [1:0] st, input logic u);
      return {u ^ st[1] ^ st[0], u ^ st[0]};
   endfunction

   function automatic int hamming(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] d;
      d = a ^ b;
      return int'(d[1]) + int'(d[0]);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] c);
      @(negedge clk20M_sig);
      in_valid = v;
      code_in  = c;
      @(posedge clk20M_sig);
      #1;
   endtask

   task automatic doReset();
      @(negedge clk20M_sig);
      reset_sig = 1'b0;
      in_valid  = 1'b0;
      code_in   = 2'b00;
      @(negedge clk20M_sig);
      reset_sig = 1'b1;
   endtask

   task automatic modelReset();
      for (int s = 0; s < 4; s++) begin
         m_pm[s]   = (s == 0) ? 0 : INIT_PM;
         m_path[s] = '0;
      end
      m_cnt   = 0;
      m_valid = 1'b0;
      m_dec   = 1'b0;
   endtask

   task automatic modelStep(input logic [1:0] c);
      int                  np    [4];
      logic [TB_DEPTH-1:0] npath [4];
      int                  a, b, p0, p1, u, best, mn;
      for (int ns = 0; ns < 4; ns++) begin
         u  = ns / 2;
         p0 = (ns % 2) * 2;
         p1 = p0 + 1;
         a  = m_pm[p0] + hamming(c, encodeBit(2'(p0), u[0]));
         b  = m_pm[p1] + hamming(c, encodeBit(2'(p1), u[0]));
         if (a > PM_SAT) a = PM_SAT;
         if (b > PM_SAT) b = PM_SAT;
         if (b < a) begin
            np[ns]    = b;
            npath[ns] = (m_path[p1] << 1) | TB_DEPTH'(u);
         end else begin
            np[ns]    = a;
            npath[ns] = (m_path[p0] << 1) | TB_DEPTH'(u);
         end
      end
      best = 0;
      for (int s = 1; s < 4; s++) if (np[s] < np[best]) best = s;
      mn = np[best];
      for (int s = 0; s < 4; s++) begin
         m_pm[s]   = np[s] - mn;
         m_path[s] = npath[s];
      end
      m_valid = (m_cnt == TB_DEPTH - 1);
      if (m_valid) m_dec = npath[best][TB_DEPTH-1];
      if (m_cnt < TB_DEPTH - 1) m_cnt++;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " out_valid"}, 32'(out_valid), 0);
      checkOutput({tag, " dec_out"},   32'(dec_out),   0);
      checkOutput({tag, " pm_min"},    32'(pm_min),    0);
      checkOutput({tag, " pm0"}, 32'(dut.pm[0]), 0);
      checkOutput({tag, " pm1"}, 32'(dut.pm[1]), INIT_PM);
      checkOutput({tag, " pm2"}, 32'(dut.pm[2]), INIT_PM);
      checkOutput({tag, " pm3"}, 32'(dut.pm[3]), INIT_PM);
   endtask

   task automatic runTable(input string tag, input int flip_idx, input int n);
      logic [1:0] c;
      for (int i = 0; i < n; i++) begin
         c = vecs[i].code;
         if (i == flip_idx) c = c ^ 2'b10;
         applyStimulus(1'b1, c);
         checkOutput($sformatf("%s valid[%0d]", tag, i), 32'(out_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid)
            checkOutput($sformatf("%s bit[%0d]", tag, i - PAD), 32'(dec_out), 32'(vecs[i].exp_bit));
         checkOutput($sformatf("%s pm_min[%0d]", tag, i), 32'(pm_min), 0);
      end
   endtask

   task automatic runGapped();
      logic last_bit;
      last_bit = 1'b0;
      for (int i = 0; i < S1_LEN; i++) begin
         applyStimulus(1'b1, vecs[i].code);
         checkOutput($sformatf("gap valid[%0d]", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            checkOutput($sformatf("gap bit[%0d]", i - PAD), 32'(dec_out), 32'(vecs[i].exp_bit));
            last_bit = vecs[i].exp_bit;
         end
         for (int g = 0; g < 3; g++) begin
            applyStimulus(1'b0, vecs[i].code ^ 2'b11);
            checkOutput($sformatf("gap idle valid[%0d.%0d]", i, g), 32'(out_valid), 0);
            checkOutput($sformatf("gap idle hold[%0d.%0d]", i, g), 32'(dec_out), 32'(last_bit));
         end
      end
   endtask

   task automatic runRandom(input logic inject);
      logic [1:0] st;
      logic [1:0] c;
      logic       u;
      int         errs;
      doReset();
      st   = 2'b00;
      errs = 0;
      for (int i = 0; i < N_RAND + PAD; i++) begin
         u  = (i < N_RAND) ? rand_bits[i][0] : 1'b0;
         c  = encodeBit(st, u);
         st = {u, st[1]};
         if (inject && i < N_RAND && (i % 12) == 5) c = c ^ (((i % 24) == 5) ? 2'b10 : 2'b01);
         applyStimulus(1'b1, c);
         if (i >= PAD) begin
            if (out_valid !== 1'b1 || dec_out !== rand_bits[i - PAD][0]) errs++;
            checkOutput($sformatf("rand%0d valid[%0d]", inject, i), 32'(out_valid), 1);
            checkOutput($sformatf("rand%0d bit[%0d]", inject, i - PAD), 32'(dec_out), 32'(rand_bits[i - PAD]));
         end else begin
            checkOutput($sformatf("rand%0d fill valid[%0d]", inject, i), 32'(out_valid), 0);
         end
      end
      $display("[TB] random stream inject=%0d done, %0d bad positions", inject, errs);
   endtask

   initial begin
      logic [1:0] s1_codes [6];
      logic       s1_bits  [6];
      int         j;

      reset_sig = 1'b0;
      in_valid  = 1'b0;
      code_in   = 2'b00;

      // Encoding of 1,0,1,1,0,0 followed by 20 zero symbols
      s1_codes = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
      s1_bits  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < S1_LEN; i++) begin
         vecs[i].code      = (i < 6) ? s1_codes[i] : 2'b00;
         vecs[i].exp_valid = (i >= PAD);
         j = i - PAD;
         vecs[i].exp_bit   = (i >= PAD && j < 6) ? s1_bits[j] : 1'b0;
      end
      for (int i = 0; i < N_RAND; i++) rand_bits[i] = int'($urandom_range(1, 0));

      $display("[TB] reset state");
      doReset();
      #1;
      checkResetState("reset");

      $display("[TB] error-free stream");
      runTable("clean", -1, S1_LEN);

      $display("[TB] single-error stream");
      doReset();
      runTable("err1", 2, S1_LEN);

      $display("[TB] gapped stream");
      doReset();
      runGapped();

      $display("[TB] random streams");
      runRandom(1'b0);
      runRandom(1'b1);

      $display("[TB] reset mid-stream");
      doReset();
      runTable("pre-reset", -1, 20);
      checkOutput("pre-reset out_valid high", 32'(out_valid), 1);
      #5;
      reset_sig = 1'b0;
      in_valid  = 1'b0;
      #1;
      checkResetState("mid-reset");
      @(posedge clk20M_sig);
      #1;
      checkOutput("mid-reset held out_valid", 32'(out_valid), 0);
      @(negedge clk20M_sig);
      reset_sig = 1'b1;
      runTable("post-reset", -1, S1_LEN);

      $display("[TB] tie handling, 40 symbols of 11");
      doReset();
      modelReset();
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 2'b11);
         modelStep(2'b11);
         checkOutput($sformatf("tie valid[%0d]", i), 32'(out_valid), 32'(m_valid));
         checkOutput($sformatf("tie bit[%0d]", i), 32'(dec_out), 32'(m_dec));
         checkOutput($sformatf("tie known[%0d]", i), 32'($isunknown(dec_out)), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
